// File: rtl/ctrl_seq_pkg.sv
// ctrl_seq_pkg: ALU opcodes, instruction opcodes, sequencer states and decode bundle for ctrl_seq.
package ctrl_seq_pkg;
  typedef enum logic [5:0] {
    ALU_NOP, ALU_LSL, ALU_LSR, ALU_STR, ALU_LDR, ALU_EMK, ALU_ADD, ALU_SUB,
    ALU_AND, ALU_ANDI, ALU_ORR, ALU_ORRI, ALU_MOV, ALU_MOVI, ALU_BEQ
  } alu_op_t;
  localparam logic [3:0] OP_LSL  = 4'h0;
  localparam logic [3:0] OP_LSR  = 4'h1;
  localparam logic [3:0] OP_STR  = 4'h2;
  localparam logic [3:0] OP_LDR  = 4'h3;
  localparam logic [3:0] OP_EMK  = 4'h4;
  localparam logic [3:0] OP_ADD  = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_AND  = 4'h7;
  localparam logic [3:0] OP_ANDI = 4'h8;
  localparam logic [3:0] OP_ORR  = 4'h9;
  localparam logic [3:0] OP_ORRI = 4'hA;
  localparam logic [3:0] OP_MOV  = 4'hB;
  localparam logic [3:0] OP_MOVI = 4'hC;
  localparam logic [3:0] OP_BEQ  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hE;
  // 4'hF is the only unassigned opcode and decodes as illegal
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } ctrl_state_t;
  typedef struct packed {
    alu_op_t alu_op;
    logic    uses_imm;
    logic    is_mem;
    logic    is_store;
    logic    is_branch;
    logic    writes_rf;
    logic    sets_ov;
    logic    illegal;
  } dec_t;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode -> ALU op and control flags.
module ctrl_decode
  import ctrl_seq_pkg::*;
(
  input  logic [3:0] op_i,
  output dec_t       dec_o
);
  always_comb begin
    dec_o = '0;
    dec_o.writes_rf = 1'b1;
    case (op_i)
      OP_LSL:  begin dec_o.alu_op = ALU_LSL;  dec_o.uses_imm = 1'b1; end
      OP_LSR:  begin dec_o.alu_op = ALU_LSR;  dec_o.uses_imm = 1'b1; end
      OP_STR:  begin
        dec_o.alu_op    = ALU_STR;
        dec_o.uses_imm  = 1'b1;
        dec_o.is_mem    = 1'b1;
        dec_o.is_store  = 1'b1;
        dec_o.writes_rf = 1'b0;
      end
      OP_LDR:  begin
        dec_o.alu_op   = ALU_LDR;
        dec_o.uses_imm = 1'b1;
        dec_o.is_mem   = 1'b1;
        dec_o.sets_ov  = 1'b1;
      end
      OP_EMK:  dec_o.alu_op = ALU_EMK;
      OP_ADD:  begin dec_o.alu_op = ALU_ADD;  dec_o.sets_ov = 1'b1; end
      OP_SUB:  begin dec_o.alu_op = ALU_SUB;  dec_o.sets_ov = 1'b1; end
      OP_AND:  dec_o.alu_op = ALU_AND;
      OP_ANDI: begin dec_o.alu_op = ALU_ANDI; dec_o.uses_imm = 1'b1; end
      OP_ORR:  dec_o.alu_op = ALU_ORR;
      OP_ORRI: begin dec_o.alu_op = ALU_ORRI; dec_o.uses_imm = 1'b1; end
      OP_MOV:  dec_o.alu_op = ALU_MOV;
      OP_MOVI: begin dec_o.alu_op = ALU_MOVI; dec_o.uses_imm = 1'b1; end
      OP_BEQ:  begin
        dec_o.alu_op    = ALU_BEQ;
        dec_o.uses_imm  = 1'b1;
        dec_o.is_branch = 1'b1;
        dec_o.writes_rf = 1'b0;
      end
      OP_HALT: dec_o.writes_rf = 1'b0;
      default: begin dec_o.writes_rf = 1'b0; dec_o.illegal = 1'b1; end
    endcase
  end
endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq: multi-cycle fetch/decode/exec sequencer driving the 8-bit ALU.
// Define CTRL_CYCLE_CNT_EN to build the saturating 16-bit run-cycle counter.
module ctrl_seq
  import ctrl_seq_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int MEM_TO = 15
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start_i,
  output logic [PC_W-1:0] instr_addr_o,
  input  logic [8:0]      instr_i,
  output logic [5:0]      alu_op_o,
  output logic [7:0]      imm_o,
  output logic [2:0]      rf_rt_addr_o,
  output logic            rf_we_o,
  input  logic [7:0]      alu_result_i,
  input  logic            alu_ov_i,
  output logic            ov_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  input  logic            mem_ack_i,
  output logic            done_o,
  output logic            err_o,
  output logic [15:0]     cycle_cnt_o
);
  localparam int TO_W = $clog2(MEM_TO + 1);
  ctrl_state_t     state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, br_off;
  logic [8:0]      instr_q, instr_d;
  logic            ov_q, ov_d, err_q, err_d, busy;
  logic [TO_W-1:0] to_q, to_d;
  logic [3:0]      op;
  dec_t            dec;
  // DECODE looks at the ROM word directly; later states use the latched copy
  assign op     = (state_q == S_DECODE) ? instr_i[8:5] : instr_q[8:5];
  assign br_off = {{(PC_W-5){instr_q[4]}}, instr_q[4:0]};
  ctrl_decode u_dec (.op_i(op), .dec_o(dec));
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ov_d    = ov_q;
    err_d   = err_q;
    to_d    = to_q;
    case (state_q)
      S_IDLE:   state_d = start_i ? S_FETCH : S_IDLE;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        instr_d = instr_i;
        state_d = (op == OP_HALT || dec.illegal) ? S_HALT : S_EXEC;
        err_d   = err_q | dec.illegal;
      end
      S_EXEC: begin
        to_d    = '0;
        state_d = dec.is_mem ? S_MEM : dec.is_branch ? S_FETCH : S_WB;
        if (dec.is_branch)
          pc_d = pc_q + ((alu_result_i == 8'd0) ? br_off : PC_W'(1));
      end
      S_MEM: begin
        if (mem_ack_i) begin
          state_d = dec.is_store ? S_FETCH : S_WB;
          pc_d    = dec.is_store ? pc_q + 1'b1 : pc_q;
        end else if (to_q == TO_W'(MEM_TO - 1)) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        pc_d    = pc_q + 1'b1;
        ov_d    = dec.sets_ov ? alu_ov_i : ov_q;
      end
      S_HALT: begin
        state_d = start_i ? S_FETCH : S_HALT;
        pc_d    = start_i ? '0 : pc_q;
        err_d   = start_i ? 1'b0 : err_q;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      ov_q    <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ov_q    <= ov_d;
      err_q   <= err_d;
      to_q    <= to_d;
    end
  end
  // ALU controls stay valid from EXEC until the instruction leaves WB/MEM
  assign busy         = state_q inside {S_EXEC, S_MEM, S_WB};
  assign alu_op_o     = busy ? dec.alu_op : ALU_NOP;
  assign imm_o        = (busy && dec.uses_imm) ? {3'b000, instr_q[4:0]} : 8'd0;
  assign rf_rt_addr_o = busy ? instr_q[4:2] : 3'd0;
  assign rf_we_o      = (state_q == S_WB) && dec.writes_rf;
  assign mem_req_o    = (state_q == S_MEM);
  assign mem_we_o     = mem_req_o && dec.is_store;
  assign done_o       = (state_q == S_HALT);
  assign err_o        = err_q;
  assign ov_o         = ov_q;
  assign instr_addr_o = pc_q;
`ifdef CTRL_CYCLE_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        parked;
  // the cycle that drops into HALT is not counted, so a run's count freezes on its last active cycle
  assign parked = (state_q == S_IDLE) || (state_q == S_HALT);
  assign cnt_d  = parked ? ((state_d == S_FETCH) ? 16'd0 : cnt_q)
                         : ((state_d != S_HALT && cnt_q != 16'hFFFF) ? cnt_q + 1'b1 : cnt_q);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
  assign cycle_cnt_o = cnt_q;
`else
  assign cycle_cnt_o = 16'd0;
`endif
endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: directed scenario bench for ctrl_seq; cycle-count expectation follows CTRL_CYCLE_CNT_EN.
module tb_ctrl_seq;
  import ctrl_seq_pkg::*;
  logic        clk = 1'b0, reset_n = 1'b0, start_i = 1'b0;
  logic [7:0]  instr_addr_o;
  logic [8:0]  instr_i = 9'd0;
  logic [5:0]  alu_op_o;
  logic [7:0]  imm_o, alu_result_i = 8'd0;
  logic [2:0]  rf_rt_addr_o;
  logic        rf_we_o, alu_ov_i = 1'b0, ov_o, mem_req_o, mem_we_o, mem_ack_i = 1'b0, done_o, err_o;
  logic [15:0] cycle_cnt_o;
  logic [8:0]  rom [256];
  int          n_chk = 0, n_fail = 0;

  ctrl_seq dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i), .instr_addr_o(instr_addr_o),
    .instr_i(instr_i), .alu_op_o(alu_op_o), .imm_o(imm_o), .rf_rt_addr_o(rf_rt_addr_o),
    .rf_we_o(rf_we_o), .alu_result_i(alu_result_i), .alu_ov_i(alu_ov_i), .ov_o(ov_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_ack_i(mem_ack_i), .done_o(done_o),
    .err_o(err_o), .cycle_cnt_o(cycle_cnt_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) instr_i <= rom[instr_addr_o];

  function automatic logic [8:0] ins(input logic [3:0] op, input logic [4:0] f);
    return {op, f};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = ins(OP_HALT, 5'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; start_i = 1'b0; mem_ack_i = 1'b0; alu_ov_i = 1'b0; alu_result_i = 8'd0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // returns just after the edge that samples start_i (state now FETCH)
  task automatic start_run();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    clear_rom();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_chk++;
    if ({instr_addr_o, alu_op_o, imm_o, rf_rt_addr_o, rf_we_o, ov_o, mem_req_o, mem_we_o,
         done_o, err_o, cycle_cnt_o} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: addr=%0d op=%0d imm=%0d rt=%0d we=%b ov=%b req=%b done=%b err=%b cnt=%0d, want all 0",
        instr_addr_o, alu_op_o, imm_o, rf_rt_addr_o, rf_we_o, ov_o, mem_req_o, done_o, err_o, cycle_cnt_o);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    mem_ack_i = 1'b1;
    repeat (4) @(negedge clk);
    mem_ack_i = 1'b0;
    n_chk++;
    if ({instr_addr_o, done_o, mem_req_o} !== '0) begin
      n_fail++; $display("FAIL idle_hold: addr=%0d done=%b req=%b, want 0 0 0", instr_addr_o, done_o, mem_req_o);
    end
  endtask

  task automatic test_movi_halt();
    int we_n = 0, we_e = -1, done_e = -1;
    logic [5:0] we_op = '0;
    logic [7:0] we_imm = '0;
    logic [15:0] exp_cnt;
    clear_rom();
    rom[0] = ins(OP_MOVI, 5'd5);
    do_reset();
    start_run();
    for (int e = 1; e <= 9; e++) begin
      @(negedge clk);
      if (rf_we_o) begin we_n++; we_e = e; we_op = alu_op_o; we_imm = imm_o; end
      if (done_o && done_e < 0) done_e = e;
    end
`ifdef CTRL_CYCLE_CNT_EN
    exp_cnt = 16'd5;
`else
    exp_cnt = 16'd0;
`endif
    n_chk++; if (we_n != 1) begin n_fail++; $display("FAIL movi_we_count: got %0d want 1", we_n); end
    n_chk++; if (we_e != 3) begin n_fail++; $display("FAIL movi_we_cycle: got %0d want 3", we_e); end
    n_chk++; if (we_op !== ALU_MOVI) begin n_fail++; $display("FAIL movi_alu_op: got %0d want %0d", we_op, ALU_MOVI); end
    n_chk++; if (we_imm !== 8'd5) begin n_fail++; $display("FAIL movi_imm: got %0d want 5", we_imm); end
    n_chk++; if (done_e != 6) begin n_fail++; $display("FAIL halt_done_cycle: got %0d want 6", done_e); end
    n_chk++; if (instr_addr_o !== 8'd1) begin n_fail++; $display("FAIL halt_pc: got %0d want 1", instr_addr_o); end
    n_chk++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL halt_err: got %b want 0", err_o); end
    n_chk++; if (cycle_cnt_o !== exp_cnt) begin n_fail++; $display("FAIL cycle_cnt: got %0d want %0d", cycle_cnt_o, exp_cnt); end
  endtask

  task automatic test_ov_flag();
    int req_n = 0;
    clear_rom();
    rom[0] = ins(OP_ADD, 5'd0);
    rom[1] = ins(OP_AND, 5'd4);
    rom[2] = ins(OP_SUB, 5'd8);
    do_reset();
    alu_ov_i = 1'b1;
    mem_ack_i = 1'b1;
    start_run();
    start_i = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      @(negedge clk);
      if (mem_req_o) req_n++;
      if (e == 3) begin
        n_chk++; if (ov_o !== 1'b0) begin n_fail++; $display("FAIL ov_before_wb: got %b want 0", ov_o); end
      end
      if (e == 4) begin
        n_chk++; if (ov_o !== 1'b1) begin n_fail++; $display("FAIL ov_add_load: got %b want 1", ov_o); end
        alu_ov_i = 1'b0;
      end
      if (e == 8) begin
        n_chk++; if (ov_o !== 1'b1) begin n_fail++; $display("FAIL ov_and_keep: got %b want 1", ov_o); end
      end
      if (e == 12) begin
        n_chk++; if (ov_o !== 1'b0) begin n_fail++; $display("FAIL ov_sub_load: got %b want 0", ov_o); end
        start_i = 1'b0;
      end
    end
    n_chk++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL ov_prog_done: got %b want 1", done_o); end
    n_chk++; if (req_n != 0) begin n_fail++; $display("FAIL stray_ack_req: got %0d want 0", req_n); end
    mem_ack_i = 1'b0;
  endtask

  task automatic test_branch();
    clear_rom();
    for (int i = 0; i < 4; i++) rom[i] = ins(OP_MOVI, 5'(i));
    rom[4] = ins(OP_BEQ, 5'b11110);
    do_reset();
    start_run();
    repeat (18) @(negedge clk);
    n_chk++;
    if ({alu_op_o, rf_rt_addr_o, imm_o} !== {ALU_BEQ, 3'b111, 8'd30}) begin
      n_fail++; $display("FAIL beq_exec_ctrl: op=%0d rt=%0d imm=%0d want %0d 7 30", alu_op_o, rf_rt_addr_o, imm_o, ALU_BEQ);
    end
    @(negedge clk);
    n_chk++; if (instr_addr_o !== 8'd2) begin n_fail++; $display("FAIL beq_taken: got %0d want 2", instr_addr_o); end
    do_reset();
    alu_result_i = 8'd3;
    start_run();
    repeat (19) @(negedge clk);
    n_chk++; if (instr_addr_o !== 8'd5) begin n_fail++; $display("FAIL beq_not_taken: got %0d want 5", instr_addr_o); end
    repeat (2) @(negedge clk);
    n_chk++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL beq_then_halt: got %b want 1", done_o); end
  endtask

  task automatic test_wrap_selfloop();
    int we_n = 0;
    clear_rom();
    rom[0]   = ins(OP_BEQ, 5'b11111);
    rom[255] = ins(OP_BEQ, 5'b00000);
    do_reset();
    start_run();
    repeat (3) @(negedge clk);
    n_chk++; if (instr_addr_o !== 8'd255) begin n_fail++; $display("FAIL pc_wrap: got %0d want 255", instr_addr_o); end
    for (int e = 4; e <= 9; e++) begin
      @(negedge clk);
      if (rf_we_o) we_n++;
    end
    n_chk++;
    if ({instr_addr_o, done_o, 8'(we_n)} !== {8'd255, 1'b0, 8'd0}) begin
      n_fail++; $display("FAIL self_loop: addr=%0d done=%b we=%0d want 255 0 0", instr_addr_o, done_o, we_n);
    end
  endtask

  task automatic test_mem_store();
    int req_n = 0, bad = 0, we_n = 0;
    clear_rom();
    rom[0] = ins(OP_STR, 5'b00100);
    do_reset();
    start_run();
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      if (rf_we_o) we_n++;
      if (mem_req_o) begin
        req_n++;
        if (!mem_we_o || alu_op_o !== ALU_STR || rf_rt_addr_o !== 3'd1) bad++;
      end
      mem_ack_i = mem_req_o && (req_n == 3);
    end
    mem_ack_i = 1'b0;
    n_chk++; if (req_n != 3) begin n_fail++; $display("FAIL str_req_cycles: got %0d want 3", req_n); end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL str_ctrl_stable: got %0d bad cycles want 0", bad); end
    n_chk++; if (we_n != 0) begin n_fail++; $display("FAIL str_no_rf_we: got %0d want 0", we_n); end
    n_chk++;
    if ({done_o, err_o, instr_addr_o} !== {1'b1, 1'b0, 8'd1}) begin
      n_fail++; $display("FAIL str_finish: done=%b err=%b addr=%0d want 1 0 1", done_o, err_o, instr_addr_o);
    end
  endtask

  task automatic test_mem_timeout();
    int req_n = 0, done_e = -1;
    clear_rom();
    rom[0] = ins(OP_LDR, 5'd0);
    do_reset();
    start_run();
    for (int e = 1; e <= 25; e++) begin
      @(negedge clk);
      if (mem_req_o) req_n++;
      if (done_o && done_e < 0) done_e = e;
    end
    n_chk++; if (req_n != 15) begin n_fail++; $display("FAIL timeout_req_cycles: got %0d want 15", req_n); end
    n_chk++; if (done_e != 18) begin n_fail++; $display("FAIL timeout_done_cycle: got %0d want 18", done_e); end
    n_chk++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b want 1", err_o); end
    rom[0] = ins(OP_MOVI, 5'd1);
    start_run();
    n_chk++;
    if ({err_o, done_o, instr_addr_o} !== {1'b0, 1'b0, 8'd0}) begin
      n_fail++; $display("FAIL restart_clears_err: err=%b done=%b addr=%0d want 0 0 0", err_o, done_o, instr_addr_o);
    end
  endtask

  task automatic test_illegal();
    int we_n = 0;
    clear_rom();
    rom[0] = ins(4'hF, 5'd3);
    do_reset();
    start_run();
    for (int e = 1; e <= 2; e++) begin
      @(negedge clk);
      if (rf_we_o) we_n++;
    end
    n_chk++;
    if ({done_o, err_o, 8'(we_n)} !== {1'b1, 1'b1, 8'd0}) begin
      n_fail++; $display("FAIL illegal_op: done=%b err=%b we=%0d want 1 1 0", done_o, err_o, we_n);
    end
  endtask

  task automatic test_reset_mid_mem();
    clear_rom();
    rom[0] = ins(OP_LDR, 5'b01000);
    do_reset();
    start_run();
    repeat (5) @(negedge clk);
    n_chk++; if (mem_req_o !== 1'b1) begin n_fail++; $display("FAIL ldr_in_mem: got %b want 1", mem_req_o); end
    #2 reset_n = 1'b0;
    #1;
    n_chk++;
    if ({instr_addr_o, alu_op_o, imm_o, rf_rt_addr_o, rf_we_o, ov_o, mem_req_o, mem_we_o,
         done_o, err_o, cycle_cnt_o} !== '0) begin
      n_fail++; $display("FAIL async_reset_mem: req=%b op=%0d rt=%0d addr=%0d want all 0", mem_req_o, alu_op_o, rf_rt_addr_o, instr_addr_o);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    alu_ov_i = 1'b1;
    start_run();
    repeat (3) @(negedge clk);
    n_chk++; if (mem_req_o !== 1'b1) begin n_fail++; $display("FAIL rerun_ldr_req: got %b want 1", mem_req_o); end
    mem_ack_i = 1'b1;
    @(negedge clk);
    mem_ack_i = 1'b0;
    n_chk++;
    if ({rf_we_o, mem_req_o, alu_op_o, rf_rt_addr_o} !== {1'b1, 1'b0, ALU_LDR, 3'd2}) begin
      n_fail++; $display("FAIL ldr_wb: we=%b req=%b op=%0d rt=%0d want 1 0 %0d 2", rf_we_o, mem_req_o, alu_op_o, rf_rt_addr_o, ALU_LDR);
    end
    @(negedge clk);
    n_chk++;
    if ({ov_o, instr_addr_o} !== {1'b1, 8'd1}) begin
      n_fail++; $display("FAIL ldr_ov_pc: ov=%b addr=%0d want 1 1", ov_o, instr_addr_o);
    end
    alu_ov_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_movi_halt();
    test_ov_flag();
    test_branch();
    test_wrap_selfloop();
    test_mem_store();
    test_mem_timeout();
    test_illegal();
    test_reset_mid_mem();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
